// File: rtl/ring_osc_meter_if.sv
// Readout-side bundle of the ring-oscillator meter: measurement requests in, results out.
// master = readout logic, slave = meter.
interface ring_osc_meter_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [CH_W-1:0]  ch_sel;
  logic             sweep;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic [CH_W-1:0]  count_ch;
  logic             count_valid;
  logic             overflow;
  logic             sweep_done;

  modport master (
    output start, ch_sel, sweep,
    input  busy, count, count_ch, count_valid, overflow, sweep_done
  );

  modport slave (
    input  start, ch_sel, sweep,
    output busy, count, count_ch, count_valid, overflow, sweep_done
  );
endinterface

// File: rtl/ring_osc_meter.sv
// Multi-channel ring-oscillator enable and gated edge-count frequency meter.
// Optional back-to-back sweep of all channels when RINGOSC_METER_SWEEP_EN is defined.
module ring_osc_meter #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CH_W          = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GATE_LOG2     = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ring_osc_meter_if.slave         bus,
  output logic [NUM_CH-1:0]       osc_ena,
  input  logic [NUM_CH-1:0]       osc_in
);

  localparam int unsigned WIN_W = GATE_LOG2 + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [WIN_W-1:0] WinLast = WIN_W'(2 ** GATE_LOG2 - 1);
  localparam logic [SET_W-1:0] SetLast = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  ChLast  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               edge_q;
  logic               osc_sel;
  logic               edge_det;
  logic               ch_ok;
  logic [CNT_W-1:0]   count_q;
  logic [CH_W-1:0]    count_ch_q;
  logic               overflow_q;

`ifdef RINGOSC_METER_SWEEP_EN
  logic               sweep_q, sweep_d;
`else
  logic               unused_sweep;
  assign unused_sweep = bus.sweep;
`endif

  assign ch_ok = 32'(bus.ch_sel) < NUM_CH;

  always_comb begin
    osc_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(ch_q) == i) osc_sel = osc_in[i];
    end
  end

  // The ring output is asynchronous; only the last synchroniser stage feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_sel};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    set_d   = set_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
`ifdef RINGOSC_METER_SWEEP_EN
    sweep_d = sweep_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef RINGOSC_METER_SWEEP_EN
        if (bus.sweep) begin
          ch_d    = '0;
          sweep_d = 1'b1;
          set_d   = '0;
          state_d = StSettle;
        end else if (bus.start && ch_ok) begin
          ch_d    = bus.ch_sel;
          set_d   = '0;
          state_d = StSettle;
        end
`else
        if (bus.start && ch_ok) begin
          ch_d    = bus.ch_sel;
          set_d   = '0;
          state_d = StSettle;
        end
`endif
      end
      StSettle: begin
        cnt_d = '0;
        sat_d = 1'b0;
        win_d = '0;
        if (set_q == SetLast) state_d = StGate;
        else                  set_d   = set_q + SET_W'(1);
      end
      StGate: begin
        // Saturate at all-ones; any further edge marks the result as overflowed.
        if (edge_det) begin
          if (&cnt_q) sat_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
        if (win_q == WinLast) state_d = StDone;
        else                  win_d   = win_q + WIN_W'(1);
      end
      StDone: begin
        state_d = StIdle;
`ifdef RINGOSC_METER_SWEEP_EN
        if (sweep_q) begin
          if (ch_q == ChLast) begin
            sweep_d = 1'b0;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            set_d   = '0;
            state_d = StSettle;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      set_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      count_ch_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      set_q   <= set_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      // Result is loaded on entry to DONE so it is visible alongside count_valid.
      if (state_q == StGate && state_d == StDone) begin
        count_q    <= cnt_d;
        count_ch_q <= ch_q;
        overflow_q <= sat_d;
      end
    end
  end

`ifdef RINGOSC_METER_SWEEP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sweep_q <= 1'b0;
    else        sweep_q <= sweep_d;
  end

  assign bus.sweep_done = (state_q == StDone) && sweep_q && (ch_q == ChLast);
`else
  assign bus.sweep_done = 1'b0;
`endif

  // Decoded from reset-cleared state so reset drops the enable asynchronously.
  always_comb begin
    osc_ena = '0;
    if (state_q == StSettle || state_q == StGate) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        osc_ena[i] = (32'(ch_q) == i);
      end
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.count_valid = (state_q == StDone);
  assign bus.count       = count_q;
  assign bus.count_ch    = count_ch_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Self-checking bench for ring_osc_meter: table vectors, corner sequences and random
// measurements against a cycle-level edge-count model of synthetic square-wave rings.
module tb_ring_osc_meter;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 3;
  localparam int CNT_W     = 3;
  localparam int GATE_LOG2 = 4;
  localparam int SETTLE    = 4;
  localparam int SYNC      = 2;
  localparam int GATE      = 1 << GATE_LOG2;
  localparam int LAT       = 1 + SETTLE + GATE;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] osc_ena;
  logic [NUM_CH-1:0] osc_in;

  ring_osc_meter_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  ring_osc_meter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .GATE_LOG2(GATE_LOG2),
    .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .osc_ena(osc_ena), .osc_in(osc_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int per[NUM_CH];
  int ph[NUM_CH];
  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;

  typedef struct {
    int ch;
    int per;
    int exp_cnt;
    bit exp_ovf;
    int poke;
  } vec_t;

  vec_t tbl[6];

  // Square wave of period per (0 = static low), value during cycle n.
  function automatic bit wave(input int ch, input int n);
    int m;
    if (per[ch] <= 0) return 1'b0;
    m = (n + ph[ch]) % per[ch];
    return m >= per[ch] / 2;
  endfunction

  // Rising edges seen through the synchroniser during the GATE cycles g0..g0+GATE-1.
  function automatic int model_edges(input int ch, input int g0);
    int raw = 0;
    for (int c = g0; c < g0 + GATE; c++) begin
      if (wave(ch, c - SYNC) && !wave(ch, c - SYNC - 1)) raw++;
    end
    return raw;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) osc_in[i] = wave(i, cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("osc_ena_onehot", 32'($countones(osc_ena) <= 1), 1);
      check("sweep_done_alone", 32'(bus.sweep_done & ~bus.count_valid), 0);
      if (bus.count_valid === 1'b1) vld_cnt++;
    end
  end

  task automatic run_meas(input int ch, input bit use_model, input int exp_cnt,
                          input bit exp_ovf, input int poke, input string name);
    int n0, v0, raw, ec;
    bit eo;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ch_sel = CH_W'(ch);
    n0 = cyc;
    v0 = vld_cnt;
    if (use_model) begin
      raw = model_edges(ch, n0 + SETTLE + 1);
      ec  = (raw > CMAX) ? CMAX : raw;
      eo  = raw > CMAX;
    end else begin
      ec = exp_cnt;
      eo = exp_ovf;
    end
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      bus.start = (i == poke);
      if (i == poke) bus.ch_sel = CH_W'(1);
      if (i == SETTLE + GATE / 2) begin
        check({name, ".osc_ena_mid"}, 32'(osc_ena), 32'(1 << ch));
        check({name, ".busy_mid"}, 32'(bus.busy), 1);
      end
      if (i == LAT - 1) check({name, ".valid_early"}, 32'(bus.count_valid), 0);
      if (i == LAT) begin
        check({name, ".valid"}, 32'(bus.count_valid), 1);
        check({name, ".count"}, 32'(bus.count), 32'(ec));
        check({name, ".count_ch"}, 32'(bus.count_ch), 32'(ch));
        check({name, ".overflow"}, 32'(bus.overflow), 32'(eo));
        check({name, ".osc_ena_done"}, 32'(osc_ena), 0);
        check({name, ".busy_done"}, 32'(bus.busy), 1);
      end
      if (i == LAT + 1) begin
        check({name, ".busy_after"}, 32'(bus.busy), 0);
        check({name, ".pulses"}, 32'(vld_cnt - v0), 1);
      end
    end
  endtask

  initial begin
    int v0, n0, raw;
    bus.start  = 1'b0;
    bus.ch_sel = '0;
    bus.sweep  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      per[i] = 0;
      ph[i]  = 0;
    end
    tbl[0] = '{ch: 2, per: 4,  exp_cnt: 4, exp_ovf: 1'b0, poke: 0};
    tbl[1] = '{ch: 0, per: 2,  exp_cnt: 7, exp_ovf: 1'b1, poke: 0};
    tbl[2] = '{ch: 0, per: 0,  exp_cnt: 0, exp_ovf: 1'b0, poke: 0};
    tbl[3] = '{ch: 3, per: 8,  exp_cnt: 2, exp_ovf: 1'b0, poke: 0};
    tbl[4] = '{ch: 1, per: 16, exp_cnt: 1, exp_ovf: 1'b0, poke: 0};
    tbl[5] = '{ch: 2, per: 4,  exp_cnt: 4, exp_ovf: 1'b0, poke: SETTLE + 5};

    repeat (3) @(negedge clk);
    check("rst.osc_ena", 32'(osc_ena), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.count", 32'(bus.count), 0);
    check("rst.count_ch", 32'(bus.count_ch), 0);
    check("rst.valid", 32'(bus.count_valid), 0);
    check("rst.overflow", 32'(bus.overflow), 0);
    check("rst.sweep_done", 32'(bus.sweep_done), 0);
    rst_n = 1'b1;

    // Table: periods dividing the window give phase-independent edge counts.
    foreach (tbl[k]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        per[i] = $urandom_range(2, 13);
        ph[i]  = $urandom_range(0, 15);
      end
      per[tbl[k].ch] = tbl[k].per;
      run_meas(tbl[k].ch, 1'b0, tbl[k].exp_cnt, tbl[k].exp_ovf, tbl[k].poke,
               $sformatf("tbl%0d", k));
    end

    // Out-of-range channel request is dropped.
    v0 = vld_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ch_sel = CH_W'(5);
    for (int i = 1; i <= LAT + 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 2 || i == LAT) begin
        check("badch.busy", 32'(bus.busy), 0);
        check("badch.osc_ena", 32'(osc_ena), 0);
      end
    end
    check("badch.pulses", 32'(vld_cnt - v0), 0);

    // Reset in the middle of GATE.
    per[3] = 4;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ch_sel = CH_W'(3);
    v0 = vld_cnt;
    for (int i = 1; i <= SETTLE + 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("midrst.osc_ena_before", 32'(osc_ena), 32'(1 << 3));
    rst_n = 1'b0;
    #1;
    check("midrst.osc_ena", 32'(osc_ena), 0);
    check("midrst.busy", 32'(bus.busy), 0);
    check("midrst.count", 32'(bus.count), 0);
    check("midrst.valid", 32'(bus.count_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("midrst.pulses", 32'(vld_cnt - v0), 0);
    check("midrst.busy_after", 32'(bus.busy), 0);
    run_meas(3, 1'b0, 4, 1'b0, 0, "postrst");

    // Random periods and phases against the model.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        per[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 13);
        ph[i]  = $urandom_range(0, 15);
      end
      run_meas($urandom_range(0, NUM_CH - 1), 1'b1, 0, 1'b0, 0, $sformatf("rnd%0d", k));
    end

    // Sweep request.
    per[0] = 4;
    per[1] = 6;
    per[2] = 8;
    per[3] = 10;
    for (int i = 0; i < NUM_CH; i++) ph[i] = $urandom_range(0, 15);
    v0 = vld_cnt;
    @(negedge clk);
    bus.sweep = 1'b1;
    n0 = cyc;
`ifdef RINGOSC_METER_SWEEP_EN
    for (int i = 1; i <= NUM_CH * LAT + 1; i++) begin
      @(negedge clk);
      bus.sweep = 1'b0;
      if (i % LAT == 0) begin
        int k;
        k = i / LAT - 1;
        raw = model_edges(k, n0 + 1 + k * LAT + SETTLE);
        check($sformatf("sweep%0d.valid", k), 32'(bus.count_valid), 1);
        check($sformatf("sweep%0d.count_ch", k), 32'(bus.count_ch), 32'(k));
        check($sformatf("sweep%0d.count", k), 32'(bus.count),
              32'((raw > CMAX) ? CMAX : raw));
        check($sformatf("sweep%0d.overflow", k), 32'(bus.overflow), 32'(raw > CMAX));
        check($sformatf("sweep%0d.done", k), 32'(bus.sweep_done), 32'(k == NUM_CH - 1));
        check($sformatf("sweep%0d.busy", k), 32'(bus.busy), 1);
      end
    end
    check("sweep.busy_after", 32'(bus.busy), 0);
    check("sweep.pulses", 32'(vld_cnt - v0), 32'(NUM_CH));
`else
    for (int i = 1; i <= NUM_CH * LAT + 1; i++) begin
      @(negedge clk);
      bus.sweep = 1'b0;
      if (i == 3 || i == LAT) begin
        check("nosweep.busy", 32'(bus.busy), 0);
        check("nosweep.osc_ena", 32'(osc_ena), 0);
      end
    end
    check("nosweep.pulses", 32'(vld_cnt - v0), 0);
    check("nosweep.done", 32'(bus.sweep_done), 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_osc_meter.md
Name: ring_osc_meter

Overview:
Multi-channel ring-oscillator controller and frequency meter. It enables one of NUM_CH externally instantiated ring oscillators and lets it settle. It then counts rising edges of the ring output over a fixed window of system-clock cycles, and reports the count with channel tag and overflow flag. It sits between the ring instances and the project's readout logic, and replaces hand-wired per-ring enables.

Parameters:
NUM_CH, 4, number of ring channels (>=1)
CH_W, 2, width of channel index (>= clog2(NUM_CH), min 1)
CNT_W, 16, edge-count width
GATE_LOG2, 10, gate window = 2^GATE_LOG2 clk cycles
SETTLE_CYCLES, 16, cycles ring runs before gating starts (>=1)
SYNC_STAGES, 2, synchroniser depth on selected ring output (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request measurement, sampled in IDLE only
ch_sel  in  CH_W  channel to measure, sampled with start
sweep  in  1  sweep request (see Optional Feature)
osc_ena  out  NUM_CH  one-hot ring enable, to ring ena inputs
osc_in  in  NUM_CH  raw ring outputs (asynchronous to clk)
busy  out  1  measurement in progress
count  out  CNT_W  last result
count_ch  out  CH_W  channel of last result
count_valid  out  1  one-cycle pulse when count/count_ch update
overflow  out  1  last result saturated
sweep_done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (async, rst_n=0): state IDLE; osc_ena=0, busy=0, count=0, count_ch=0, count_valid=0, overflow=0, sweep_done=0. Synchroniser, edge register, window and edge counters are cleared. Reset mid-measurement forces osc_ena=0 immediately (asynchronously). No result is produced.
- Input path: osc_in[ch] is selected by a mux on the latched channel, then passes through SYNC_STAGES flops and one edge register. edge = sync_out & ~edge_reg.
- FSM states: IDLE, SETTLE, GATE, DONE.
- IDLE: on start=1 with ch_sel<NUM_CH, latch ch and go to SETTLE. start with ch_sel>=NUM_CH is ignored. busy stays 0 and no pulse is produced.
- SETTLE: osc_ena[ch]=1, busy=1. Lasts exactly SETTLE_CYCLES cycles. The edge counter is cleared. Synchroniser edges are not counted.
- GATE: osc_ena[ch]=1, busy=1. Lasts exactly 2^GATE_LOG2 cycles. On each cycle with edge=1 the edge counter increments. At all-ones the counter holds and a sticky sat flag is set.
- DONE (1 cycle): count<=edge counter, count_ch<=ch, overflow<=sat, count_valid=1, osc_ena=0, busy=1. Next state is IDLE. busy=0 from the following cycle.
- Latency: start cycle T gives count_valid at T+1+SETTLE_CYCLES+2^GATE_LOG2.
- start while busy=1 is ignored, not queued.
- count, count_ch and overflow hold between DONE cycles.
- osc_ena is never multi-hot.
- Window counter width is GATE_LOG2+1. Measurable frequency is < f_clk/2; higher ring rates must be prescaled upstream.

Optional Feature:
Macro RINGOSC_METER_SWEEP_EN.
- Defined: in IDLE, sweep=1 (priority over start) measures channels 0..NUM_CH-1 back to back. Each channel runs full SETTLE and GATE and gets its own DONE with a count_valid pulse. DONE of channel k goes directly to SETTLE of k+1. After DONE of channel NUM_CH-1, sweep_done pulses for 1 cycle, coincident with that final count_valid. busy stays 1 through the whole sweep. start and sweep are ignored during a sweep.
- Undefined: the sweep input is ignored and sweep_done is tied to 0. Sweep logic and the sweep channel counter are not synthesised.

Test Plan:
1. NUM_CH=4, GATE_LOG2=4, SETTLE_CYCLES=4. start with ch_sel=2, osc_in[2] square of period 4 clk -> osc_ena=4'b0100 for 20 cycles. count_valid at T+21 with count=4 (+/-1 for phase), count_ch=2, overflow=0.
2. CNT_W=3, GATE_LOG2=4, osc_in period 2 clk (8 edges) -> count=7, overflow=1. Then osc_in static 0 -> count=0, overflow=0.
3. start pulsed again 5 cycles into GATE with ch_sel=1 -> ignored. Single count_valid, count_ch unchanged, osc_ena stays one-hot on the original channel.
4. NUM_CH=3, CH_W=2, start with ch_sel=3 -> busy stays 0, osc_ena=0, no count_valid.
5. rst_n low for 1 cycle mid-GATE -> osc_ena=0 and busy=0 immediately, count=0, no count_valid. A new start then gives a correct result.
6. With RINGOSC_METER_SWEEP_EN and NUM_CH=4, sweep=1 with distinct osc_in periods 4/6/8/10 clk -> four count_valid pulses with count_ch 0,1,2,3. sweep_done coincides with the 4th pulse. Without the macro, the same stimulus produces no activity.
